// File: rtl/ahb_rr_arbiter_dmam.sv
`default_nettype none
// ============================================================================
// Module   : ahb_rr_arbiter_dmam
// Purpose  : Address-phase arbiter that shares one AHB output stage between
//            NUM_PORTS bus-switch input ports on the DMA-side bus matrix.
//            The scheme is round-robin. The grant is held for locked sequences
//            and for defined-length bursts. Wait states freeze all state.
// Options  : define AHB_ARB_FIXED_PRIORITY_EN to select fixed priority,
//            where the lowest index wins. Lock and burst hold still apply.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_rr_arbiter_dmam #(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port
);

  localparam logic [1:0]      c_trans_idle   = 2'b00;
  localparam logic [1:0]      c_trans_busy   = 2'b01;
  localparam logic [1:0]      c_trans_nonseq = 2'b10;
  localparam logic [1:0]      c_trans_seq    = 2'b11;
  localparam logic [PORT_W:0] c_num_ports    = NUM_PORTS[PORT_W:0];

  logic [3:0]        r_beat_cnt;
  logic [3:0]        w_beat_nxt;
  logic              w_hold;
  logic              w_found;
  logic [PORT_W-1:0] w_winner;
  logic [PORT_W-1:0] w_idx;
`ifndef AHB_ARB_FIXED_PRIORITY_EN
  logic [PORT_W-1:0] r_last_grant;
  logic [PORT_W:0]   w_sum;
`endif

  // Remaining-SEQ-beat count after this edge, derived from the routed control
  always_comb begin
    w_beat_nxt = r_beat_cnt;
    if (!HSELM) begin
      w_beat_nxt = 4'd0;
    end else begin
      case (HTRANSM)
        c_trans_nonseq: begin
          case (HBURSTM)
            3'b010, 3'b011: w_beat_nxt = 4'd3;   // WRAP4 / INCR4
            3'b100, 3'b101: w_beat_nxt = 4'd7;   // WRAP8 / INCR8
            3'b110, 3'b111: w_beat_nxt = 4'd15;  // WRAP16 / INCR16
            default:        w_beat_nxt = 4'd0;   // SINGLE / INCR are never held
          endcase
        end
        c_trans_seq:  w_beat_nxt = (r_beat_cnt != 4'd0) ? r_beat_cnt - 4'd1 : 4'd0;
        c_trans_busy: w_beat_nxt = r_beat_cnt;
        c_trans_idle: w_beat_nxt = 4'd0;         // early burst termination
        default:      w_beat_nxt = r_beat_cnt;
      endcase
    end
  end

  // Hold decision uses the post-update count, so the last beat releases the bus
  always_comb begin
    w_hold = HMASTLOCKM | (w_beat_nxt != 4'd0);
  end

  // Pick the winning port among the current requests
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
`ifdef AHB_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_idx = PORT_W'(i);
      if (!w_found && req_port[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
`else
    // Start just after the last grantee and wrap, so the last grantee comes last
    w_sum = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      w_sum = {1'b0, r_last_grant} + (PORT_W+1)'(i);
      if (w_sum >= c_num_ports) begin
        w_sum = w_sum - c_num_ports;
      end
      w_idx = w_sum[PORT_W-1:0];
      if (!w_found && req_port[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
`endif
  end

  // Grant, idle flag and beat count advance only on edges with HREADYM=1
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port <= '0;
      no_port      <= 1'b1;
      r_beat_cnt   <= 4'd0;
    end else if (HREADYM) begin
      r_beat_cnt <= w_beat_nxt;
      if (!w_hold) begin
        if (w_found) begin
          addr_in_port <= w_winner;
          no_port      <= 1'b0;
        end else begin
          // addr_in_port stays parked so the data-phase mux remains stable
          no_port <= 1'b1;
        end
      end
    end
  end

`ifndef AHB_ARB_FIXED_PRIORITY_EN
  // Round-robin pointer: reset value NUM_PORTS-1 makes port 0 win first
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_last_grant <= PORT_W'(NUM_PORTS - 1);
    end else if (HREADYM && !w_hold && w_found) begin
      r_last_grant <= w_winner;
    end
  end
`endif

  // The granted index must always address an existing port
  a_idx_range : assert property (@(posedge HCLK) disable iff (!HRESETn)
                                 ({1'b0, addr_in_port} < c_num_ports));

endmodule
`default_nettype wire

// File: tb/tb_ahb_rr_arbiter_dmam.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_rr_arbiter_dmam
// Purpose  : Self-checking bench for ahb_rr_arbiter_dmam. It applies directed
//            scenarios followed by random traffic. A behavioural model tracks
//            the grant, the idle flag and the remaining burst beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_rr_arbiter_dmam;

  localparam int N  = 2;
  localparam int PW = 1;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_WRAP8  = 3'd4;
  localparam logic [2:0] B_INCR16 = 3'd7;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [N-1:0]  req_port;
  logic          HREADYM;
  logic          HSELM;
  logic [1:0]    HTRANSM;
  logic [2:0]    HBURSTM;
  logic          HMASTLOCKM;
  logic [PW-1:0] addr_in_port;
  logic          no_port;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: grant, idle flag, remaining SEQ beats and round-robin pointer
  int m_grant;
  int m_none;
  int m_beats;
  int m_last;
  // Number of SEQ beats that follow a NONSEQ, for each HBURST encoding
  int burst_len [8] = '{0, 0, 3, 3, 7, 7, 15, 15};

  ahb_rr_arbiter_dmam #(.NUM_PORTS(N), .PORT_W(PW)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req_port     (req_port),
    .HREADYM      (HREADYM),
    .HSELM        (HSELM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_grant = 0;
    m_none  = 1;
    m_beats = 0;
    m_last  = N - 1;
  endtask

  // Apply the arbitration rules to the inputs present at the coming edge
  task automatic model_edge();
    int p;
    bit hit;
    if (!HREADYM) return;
    if (!HSELM)                  m_beats = 0;
    else if (HTRANSM == T_NONSEQ) m_beats = burst_len[HBURSTM];
    else if (HTRANSM == T_SEQ)    m_beats = (m_beats > 0) ? m_beats - 1 : 0;
    else if (HTRANSM == T_IDLE)   m_beats = 0;
    if (HMASTLOCKM || m_beats != 0) return;
    hit = 0;
    p = 0;
`ifdef AHB_ARB_FIXED_PRIORITY_EN
    for (int k = 0; k < N && !hit; k++) begin
      if (req_port[k]) begin hit = 1; p = k; end
    end
`else
    for (int k = 1; k <= N && !hit; k++) begin
      if (req_port[(m_last + k) % N]) begin hit = 1; p = (m_last + k) % N; end
    end
`endif
    if (hit) begin
      m_grant = p;
      m_none  = 0;
      m_last  = p;
    end else begin
      m_none = 1;
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic rdy, input logic sel,
                       input logic [1:0] tr, input logic [2:0] bu, input logic lk);
    req_port   = r;
    HREADYM    = rdy;
    HSELM      = sel;
    HTRANSM    = tr;
    HBURSTM    = bu;
    HMASTLOCKM = lk;
  endtask

  // Advance one clock and compare both outputs against the model
  task automatic step(input string tag);
    model_edge();
    @(posedge HCLK);
    #1;
    check_val({tag, "_grant"}, int'(addr_in_port), m_grant);
    check_val({tag, "_noport"}, int'(no_port), m_none);
  endtask

  initial begin
    HRESETn = 1'b0;
    drive('0, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0);
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    check_val("rst_grant", int'(addr_in_port), 0);
    check_val("rst_noport", int'(no_port), 1);
    HRESETn = 1'b1;

    // Idle after reset: parked on port 0, nobody granted
    for (int i = 0; i < 5; i++) begin
      step("idle");
      check_val("idle_noport_c", int'(no_port), 1);
    end

    // Fairness: both ports always requesting single transfers
    drive(2'b11, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("fair");
`ifdef AHB_ARB_FIXED_PRIORITY_EN
      check_val("fair_c", int'(addr_in_port), 0);
`else
      check_val("fair_c", int'(addr_in_port), i % 2);
`endif
    end

    // INCR4 from port 0 keeps the bus for all four beats
    drive(2'b01, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step("b_pre");
    drive(2'b11, 1'b1, 1'b1, T_NONSEQ, B_INCR4, 1'b0); step("b_ns");
    check_val("b_ns_c", int'(addr_in_port), 0);
    drive(2'b11, 1'b1, 1'b1, T_SEQ, B_INCR4, 1'b0);    step("b_s1");
    step("b_s2");
    check_val("b_s2_c", int'(addr_in_port), 0);
    drive(2'b10, 1'b1, 1'b1, T_SEQ, B_INCR4, 1'b0);    step("b_s3");
    check_val("b_end_c", int'(addr_in_port), 1);

    // Same burst with BUSY beats and wait states in the middle
    drive(2'b01, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step("w_pre");
    drive(2'b11, 1'b1, 1'b1, T_NONSEQ, B_INCR4, 1'b0); step("w_ns");
    drive(2'b11, 1'b1, 1'b1, T_BUSY, B_INCR4, 1'b0);   step("w_b1");
    drive(2'b11, 1'b0, 1'b1, T_IDLE, B_INCR4, 1'b0);   step("w_ws1");
    drive(2'b11, 1'b1, 1'b1, T_SEQ, B_INCR4, 1'b0);    step("w_s1");
    drive(2'b11, 1'b1, 1'b1, T_BUSY, B_INCR4, 1'b0);   step("w_b2");
    drive(2'b11, 1'b0, 1'b1, T_NONSEQ, B_INCR16, 1'b0); step("w_ws2");
    drive(2'b11, 1'b1, 1'b1, T_SEQ, B_INCR4, 1'b0);    step("w_s2");
    check_val("w_s2_c", int'(addr_in_port), 0);
    drive(2'b10, 1'b1, 1'b1, T_SEQ, B_INCR4, 1'b0);    step("w_s3");
    check_val("w_end_c", int'(addr_in_port), 1);

    // Port 1 WRAP8 terminated early by IDLE after two SEQ beats
    drive(2'b11, 1'b1, 1'b1, T_NONSEQ, B_WRAP8, 1'b0); step("e_ns");
    drive(2'b11, 1'b1, 1'b1, T_SEQ, B_WRAP8, 1'b0);    step("e_s1");
    step("e_s2");
    check_val("e_s2_c", int'(addr_in_port), 1);
    drive(2'b11, 1'b1, 1'b1, T_IDLE, B_WRAP8, 1'b0);   step("e_idle");
    check_val("e_end_c", int'(addr_in_port), 0);

    // Locked single transfers on port 0
    drive(2'b11, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b1);
    for (int i = 0; i < 3; i++) step("lk");
    check_val("lk_c", int'(addr_in_port), 0);
    drive(2'b10, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0); step("lk_drop");
    check_val("lk_end_c", int'(addr_in_port), 1);

    // Asynchronous reset in the middle of an INCR16 burst on port 1
    drive(2'b10, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0);   step("r_pre");
    drive(2'b11, 1'b1, 1'b1, T_NONSEQ, B_INCR16, 1'b0); step("r_ns");
    drive(2'b11, 1'b1, 1'b1, T_SEQ, B_INCR16, 1'b0);
    for (int i = 0; i < 5; i++) step("r_seq");
    check_val("r_mid_c", int'(addr_in_port), 1);
    HRESETn = 1'b0;
    #2;
    check_val("r_async_grant", int'(addr_in_port), 0);
    check_val("r_async_noport", int'(no_port), 1);
    model_reset();
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    drive(2'b01, 1'b1, 1'b1, T_BUSY, B_INCR16, 1'b0);   step("r_post");
    check_val("r_post_c", int'(no_port), 0);

    // Random traffic checked against the model every cycle
    for (int i = 0; i < 400; i++) begin
      drive(N'($urandom_range(0, (1 << N) - 1)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 1) != 0) ? T_SEQ : 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0));
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
